// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: fetch/decode/execute sequencing with a
// bounded memory handshake and a sticky fault state.
module multicycle_control #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic [1:0]            pc_src,
    output logic                  alu_src_a,
    output logic [2:0]            alu_src_b,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  fault,
    output logic                  instr_done,
    output logic [3:0]            state
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
    // DECODE | branch target into ALUOut, dispatch on opcode
    // MEMADR | effective address for lw/sw
    // MEMRD  | data read, wait for mem_ready
    // MEMWB  | MDR -> rt
    // MEMWR  | data write, wait for mem_ready
    // RTEXEC | R-type ALU operation
    // ALUWB  | ALUOut -> rd
    // BRANCH | beq/bne compare and conditional PC load
    // IEXEC  | immediate ALU operation
    // IWB    | ALUOut -> rt
    // JUMP   | PC <= jump target
    // JAL    | PC <= jump target, $31 <= PC
    // JR     | PC <= register A
    // FAULT  | sticky error, left only by reset
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_FAULT  = 4'd15
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b1100;
    localparam logic [3:0] ALU_SRAV = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    // {valid, alu code}
    function automatic logic [4:0] r_decode(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: r_decode = {1'b1, ALU_ADD};
            6'b100010, 6'b100011: r_decode = {1'b1, ALU_SUB};
            6'b100100:            r_decode = {1'b1, ALU_AND};
            6'b100101:            r_decode = {1'b1, ALU_OR};
            6'b100110:            r_decode = {1'b1, ALU_XOR};
            6'b100111:            r_decode = {1'b1, ALU_NOR};
            6'b101010:            r_decode = {1'b1, ALU_SLT};
            6'b101011:            r_decode = {1'b1, ALU_SLTU};
            6'b000000:            r_decode = {1'b1, ALU_SLL};
            6'b000010:            r_decode = {1'b1, ALU_SRL};
            6'b000011:            r_decode = {1'b1, ALU_SRA};
            6'b000100:            r_decode = {1'b1, ALU_SLLV};
            6'b000110:            r_decode = {1'b1, ALU_SRLV};
            6'b000111:            r_decode = {1'b1, ALU_SRAV};
            default:              r_decode = 5'b0_0000;
        endcase
    endfunction

    // {valid, zero-extended immediate, alu code}
    function automatic logic [5:0] i_decode(input logic [5:0] op);
        case (op)
            6'b001000: i_decode = {2'b10, ALU_ADD};
            6'b001001: i_decode = {2'b10, ALU_ADD};
            6'b001010: i_decode = {2'b10, ALU_SLT};
            6'b001011: i_decode = {2'b10, ALU_SLTU};
            6'b001111: i_decode = {2'b10, ALU_LUI};
            6'b001100: i_decode = {2'b11, ALU_AND};
            6'b001101: i_decode = {2'b11, ALU_OR};
            6'b001110: i_decode = {2'b11, ALU_XOR};
            default:   i_decode = 6'b00_0000;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [4:0]       r_dec;
    logic [5:0]       i_dec;
    logic             mem_state;
    logic             timeout;
    logic [3:0]       alu_code;

    assign r_dec     = r_decode(funct);
    assign i_dec     = i_decode(opcode);
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = mem_state && !mem_ready && (wait_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                state_d = S_FAULT;
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE) begin
                    if (funct == FN_JR) state_d = S_JR;
                    else if (r_dec[4])  state_d = S_RTEXEC;
                end
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
                else if (opcode == OP_J)   state_d = S_JUMP;
                else if (opcode == OP_JAL) state_d = S_JAL;
                else if (i_dec[5])         state_d = S_IEXEC;
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_RTEXEC: state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH,
            S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase
    end

    // Counter restarts on any state change so each handshake gets its own budget.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)          wait_cnt_d = '0;
        else if (mem_state && !mem_ready) wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 3'b000;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_code   = ALU_ADD;
        fault      = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 3'b001;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = 3'b011;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 3'b010;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_RTEXEC: begin
                alu_src_a = 1'b1;
                alu_code  = r_dec[3:0];
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_code   = ALU_SUB;
                pc_src     = 2'b01;
                pc_en      = (opcode == OP_BNE) ? ~zero : zero;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = i_dec[4] ? 3'b100 : 3'b010;
                alu_code  = i_dec[3:0];
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = 2'b11;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
        if (reset) begin
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 3'b000;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_code   = ALU_ADD;
            fault      = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign alu_control = ALU_CTRL_W'(alu_code);
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle scripts built
// from the instruction-level rules, replayed against the DUT with random waits.
module tb_multicycle_control;
    localparam int AW  = 6;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic iord, mem_read, mem_write, ir_write, pc_en, alu_src_a, reg_write, fault, instr_done;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_src_b;
    logic [AW-1:0] alu_control;
    logic [3:0] state;

    multicycle_control #(.ALU_CTRL_W(AW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_control(alu_control), .fault(fault),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic iord, mrd, mwr, irw, pce;
        logic [1:0] pcs;
        logic asa;
        logic [2:0] asb;
        logic rw;
        logic [1:0] rd, m2r;
        logic [3:0] alu;
        logic flt, done;
    } outs_t;

    typedef struct packed {
        logic rst, mr, zr;
        logic [5:0] op, fn;
        outs_t e;
    } step_t;

    step_t plan[$];
    outs_t exp_o, act;
    logic exp_v = 1'b0;
    int checks = 0, errors = 0, cyc = 0, last_done = -1;
    logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;

    // instruction tables: R-type funct -> ALU code; I-type opcode -> ALU code, B select
    logic [5:0] r_fn   [16] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                                6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    logic [3:0] r_code [16] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10,
                                4'd8, 4'd9, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13};
    logic [5:0] i_op   [8]  = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15};
    logic [3:0] i_code [8]  = '{4'd0, 4'd0, 4'd8, 4'd9, 4'd2, 4'd3, 4'd4, 4'd14};
    logic [2:0] i_srcb [8]  = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd2};

    assign act = {state, iord, mem_read, mem_write, ir_write, pc_en, pc_src, alu_src_a,
                  alu_src_b, reg_write, reg_dst, mem_to_reg, alu_control[3:0], fault, instr_done};

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (exp_v) begin
            checks = checks + 1;
            if (act !== exp_o || alu_control[AW-1:4] !== 2'b00) begin
                errors = errors + 1;
                $display("FAIL outputs cyc=%0d state got %0d exp %0d vector got %h exp %h alu_hi %b",
                         cyc, act.st, exp_o.st, act, exp_o, alu_control[AW-1:4]);
            end
        end
        if (instr_done === 1'b1) last_done = cyc;
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t o(input logic [3:0] st);
        outs_t x = '0;
        x.st = st;
        return x;
    endfunction

    function automatic bit def_op(input logic [5:0] op);
        return op == 6'd0 || op == 6'd2 || op == 6'd3 || op == 6'd4 || op == 6'd5 ||
               (op >= 6'd8 && op <= 6'd15) || op == 6'd35 || op == 6'd43;
    endfunction

    function automatic bit def_fn(input logic [5:0] f);
        bit d = (f == 6'd8);
        for (int i = 0; i < 16; i++) if (r_fn[i] == f) d = 1'b1;
        return d;
    endfunction

    task automatic push(input logic rst, input logic mr, input logic zr, input outs_t e);
        step_t s;
        s.rst = rst; s.mr = mr; s.zr = zr; s.op = cur_op; s.fn = cur_fn; s.e = e;
        plan.push_back(s);
    endtask

    task automatic fault_seq();
        int n = $urandom_range(2, 4);
        outs_t x = o(4'd15);
        x.flt = 1'b1;
        for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), x);
        push(1'b1, rb(), rb(), o(4'd15));
    endtask

    function automatic outs_t fetch_wait();
        outs_t x = o(4'd0);
        x.mrd = 1'b1; x.asb = 3'b001;
        return x;
    endfunction

    task automatic fetch_phase(input int w, output bit faulted);
        outs_t x;
        int n = (w >= TMO) ? TMO : w;
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, rb(), fetch_wait());
        if (w >= TMO) begin
            fault_seq();
            faulted = 1'b1;
        end else begin
            x = fetch_wait(); x.irw = 1'b1; x.pce = 1'b1;
            push(1'b0, 1'b1, rb(), x);
            faulted = 1'b0;
        end
    endtask

    task automatic mem_phase(input logic [3:0] st, input bit wr, input int w, output bit faulted);
        outs_t x = o(st);
        int n = (w >= TMO) ? TMO : w;
        x.iord = 1'b1;
        if (wr) x.mwr = 1'b1; else x.mrd = 1'b1;
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, rb(), x);
        if (w >= TMO) begin
            fault_seq();
            faulted = 1'b1;
        end else begin
            if (wr) x.done = 1'b1;
            push(1'b0, 1'b1, rb(), x);
            faulted = 1'b0;
        end
    endtask

    task automatic begin_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                               output bit faulted);
        outs_t x = o(4'd1);
        cur_op = op; cur_fn = fn;
        fetch_phase(wf, faulted);
        if (!faulted) begin
            x.asb = 3'b011;
            push(1'b0, rb(), rb(), x);
        end
    endtask

    // k: 0 lw, 1 sw, 2 R-type, 3 jr, 4 beq/bne, 5 I-type, 6 j, 7 jal, 8 bad opcode, 9 bad funct
    task automatic do_instr(input int k, input int sel, input logic z, input int wf, input int wm);
        bit f;
        outs_t x;
        logic [5:0] v;
        case (k)
            0, 1: begin
                begin_instr((k == 0) ? 6'd35 : 6'd43, 6'($urandom), wf, f);
                if (!f) begin
                    x = o(4'd2); x.asa = 1'b1; x.asb = 3'b010;
                    push(1'b0, rb(), rb(), x);
                    mem_phase((k == 0) ? 4'd3 : 4'd5, k == 1, wm, f);
                    if (!f && k == 0) begin
                        x = o(4'd4); x.rw = 1'b1; x.m2r = 2'b01; x.done = 1'b1;
                        push(1'b0, rb(), rb(), x);
                    end
                end
            end
            2: begin
                begin_instr(6'd0, r_fn[sel % 16], wf, f);
                if (!f) begin
                    x = o(4'd6); x.asa = 1'b1; x.alu = r_code[sel % 16];
                    push(1'b0, rb(), rb(), x);
                    x = o(4'd7); x.rw = 1'b1; x.rd = 2'b01; x.done = 1'b1;
                    push(1'b0, rb(), rb(), x);
                end
            end
            3: begin
                begin_instr(6'd0, 6'd8, wf, f);
                if (!f) begin
                    x = o(4'd13); x.pcs = 2'b11; x.pce = 1'b1; x.done = 1'b1;
                    push(1'b0, rb(), rb(), x);
                end
            end
            4: begin
                begin_instr((sel % 2 == 1) ? 6'd5 : 6'd4, 6'($urandom), wf, f);
                if (!f) begin
                    x = o(4'd8); x.asa = 1'b1; x.alu = 4'd1; x.pcs = 2'b01; x.done = 1'b1;
                    x.pce = (sel % 2 == 1) ? ~z : z;
                    push(1'b0, rb(), z, x);
                end
            end
            5: begin
                begin_instr(i_op[sel % 8], 6'($urandom), wf, f);
                if (!f) begin
                    x = o(4'd9); x.asa = 1'b1; x.asb = i_srcb[sel % 8]; x.alu = i_code[sel % 8];
                    push(1'b0, rb(), rb(), x);
                    x = o(4'd10); x.rw = 1'b1; x.done = 1'b1;
                    push(1'b0, rb(), rb(), x);
                end
            end
            6, 7: begin
                begin_instr((k == 6) ? 6'd2 : 6'd3, 6'($urandom), wf, f);
                if (!f) begin
                    x = o((k == 6) ? 4'd11 : 4'd12); x.pcs = 2'b10; x.pce = 1'b1; x.done = 1'b1;
                    if (k == 7) begin x.rw = 1'b1; x.rd = 2'b10; x.m2r = 2'b10; end
                    push(1'b0, rb(), rb(), x);
                end
            end
            8: begin
                v = 6'(sel);
                while (def_op(v)) v = 6'($urandom);
                begin_instr(v, 6'($urandom), wf, f);
                if (!f) fault_seq();
            end
            default: begin
                v = 6'(sel);
                while (def_fn(v)) v = 6'($urandom);
                begin_instr(6'd0, v, wf, f);
                if (!f) fault_seq();
            end
        endcase
    endtask

    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk); #1;
            reset = s.rst; mem_ready = s.mr; zero = s.zr; opcode = s.op; funct = s.fn;
            exp_o = s.e; exp_v = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    // literal zero-wait latency from FETCH entry to the instr_done cycle
    task automatic run_timed(input int lat, input string name);
        int start = cyc;
        last_done = -1;
        run_plan();
        checks = checks + 1;
        if (last_done - start != lat) begin
            errors = errors + 1;
            $display("FAIL latency %s got %0d required %0d", name, last_done - start, lat);
        end
    endtask

    function automatic int rwait();
        int r = $urandom_range(0, 19);
        return (r == 0) ? TMO : (r == 1) ? TMO - 1 : $urandom_range(0, 3);
    endfunction

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
        push(1'b1, 1'b0, 1'b0, o(4'd0));
        run_plan();

        do_instr(2, 0, 1'b0, 0, 0);  run_timed(4, "add");
        do_instr(0, 0, 1'b0, 0, 0);  run_timed(5, "lw");
        do_instr(1, 0, 1'b0, 0, 0);  run_timed(4, "sw");
        do_instr(5, 4, 1'b0, 0, 0);  run_timed(4, "andi");
        do_instr(4, 0, 1'b1, 0, 0);  run_timed(3, "beq");
        do_instr(4, 1, 1'b0, 0, 0);  run_timed(3, "bne_z0");
        do_instr(4, 1, 1'b1, 0, 0);  run_timed(3, "bne_z1");
        do_instr(6, 0, 1'b0, 0, 0);  run_timed(3, "j");
        do_instr(7, 0, 1'b0, 0, 0);  run_timed(3, "jal");
        do_instr(3, 0, 1'b0, 0, 0);  run_timed(3, "jr");

        do_instr(0, 0, 1'b0, 0, 3);         run_plan();
        do_instr(2, 5, 1'b0, TMO, 0);       run_plan();
        do_instr(8, 63, 1'b0, 0, 0);        run_plan();
        do_instr(9, 1, 1'b0, 0, 0);         run_plan();
        do_instr(0, 0, 1'b0, TMO - 1, TMO); run_plan();
        do_instr(1, 0, 1'b0, 1, TMO - 1);   run_plan();

        begin
            bit f;
            outs_t x;
            begin_instr(6'd43, 6'd0, 0, f);
            x = o(4'd2); x.asa = 1'b1; x.asb = 3'b010;
            push(1'b0, 1'b0, 1'b0, x);
            x = o(4'd5); x.iord = 1'b1; x.mwr = 1'b1;
            push(1'b0, 1'b0, 1'b0, x);
            push(1'b1, 1'b0, 1'b0, o(4'd5));
            for (int i = 0; i < 10; i++) push(1'b0, 1'b0, rb(), fetch_wait());
            push(1'b1, 1'b0, 1'b0, o(4'd0));
            run_plan();
        end
        do_instr(5, 7, 1'b0, TMO - 1, 0); run_plan();

        for (int n = 0; n < 200; n++) begin
            do_instr($urandom_range(0, 9), $urandom_range(0, 63), rb(), rwait(), rwait());
            run_plan();
        end

        exp_v = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
